adder_bist_driver: RTL

Built-in self-test driver for the carry-skip adder core: it generates operand/carry-in vectors, presents them to a combinational adder under test, captures the adder's sum and carry-out, and checks them against a behavioural reference sum. It sits on the input side of the adder inside the TinyTapeout wrapper. A single `start` pulse runs a complete test, and the block reports pass/fail, error count and first failing vector index.

---
 rtl/adder_bist_pkg.sv | 57 +++++
 rtl/bist_lfsr16.sv | 38 +++
 rtl/adder_bist_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST driver: FSM states, the
// operand-vector record, LFSR constants and the fixed corner vectors.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  // One stimulus vector for the 8-bit adder under test.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } bist_vec_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  // Corner vectors: all-zero, carry ripple through every bit, maximum sum
  // with carry-in, and alternating bit pattern with carry-in.
  localparam bist_vec_t CORNER_VEC0 = '{a: 8'h00, b: 8'h00, cin: 1'b0};
  localparam bist_vec_t CORNER_VEC1 = '{a: 8'hFF, b: 8'h01, cin: 1'b0};
  localparam bist_vec_t CORNER_VEC2 = '{a: 8'hFF, b: 8'hFF, cin: 1'b1};
  localparam bist_vec_t CORNER_VEC3 = '{a: 8'h55, b: 8'hAA, cin: 1'b1};

  localparam int unsigned NUM_CORNERS = 4;

  // One step of the 16-bit right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Corner vector lookup for indices 0..3.
  function automatic bist_vec_t corner_vec(input logic [1:0] idx);
    bist_vec_t v;
    unique case (idx)
      2'd0:    v = CORNER_VEC0;
      2'd1:    v = CORNER_VEC1;
      2'd2:    v = CORNER_VEC2;
      default: v = CORNER_VEC3;
    endcase
    return v;
  endfunction

  // Pseudo-random vector taken from an LFSR state.
  function automatic bist_vec_t vec_from_lfsr(input logic [15:0] l);
    bist_vec_t v;
    v.a   = l[7:0];
    v.b   = l[15:8];
    v.cin = l[3];
    return v;
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Galois LFSR used as the pseudo-random operand source.
// A load takes priority over a step in the same cycle.
module bist_lfsr16
  import adder_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next state: reload from seed, advance one step, or hold.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  // State register; resets to the default seed so it is never all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= DEFAULT_LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/adder_bist_driver.sv
// BIST driver for the carry-skip adder: drives corner and LFSR vectors,
// captures the adder result one cycle later and compares it against a
// reference sum. Reports pass/fail, saturating error count and the index
// of the first failing vector.
module adder_bist_driver
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_fail_idx
);

  localparam logic [7:0] LAST_IDX   = 8'(NUM_VECTORS - 1);
  // Index after which the next vector comes from the LFSR.
  localparam logic [7:0] LAST_CORNR = 8'(NUM_CORNERS - 1);

  // Error counter increment that sticks at full scale.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  bist_state_e      state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             cin_q, cin_d;
  logic [WIDTH:0]   cap_q, cap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       ffi_q, ffi_d;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [15:0]      lfsr_value;
  logic [15:0]      lfsr_stepped;
  logic [7:0]       nxt_idx;
  logic             nxt_from_lfsr;
  bist_vec_t        load_vec;
  logic [WIDTH:0]   ref_sum;
  logic             mismatch;

  bist_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (LFSR_SEED),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // The operand register must see the post-step LFSR value on the same edge
  // the LFSR itself advances, so the step is also computed here.
  assign lfsr_stepped  = lfsr_next(lfsr_value);
  assign nxt_idx       = idx_q + 8'd1;
  assign nxt_from_lfsr = (idx_q >= LAST_CORNR);

  // Reference result at full WIDTH+1 precision, from the registered operands.
  assign ref_sum  = {1'b0, op_a_q} + {1'b0, op_b_q} + {{WIDTH{1'b0}}, cin_q};
  assign mismatch = (cap_q != ref_sum);

  // Vector mux: vector 0 on start, otherwise the vector for the next index.
  always_comb begin
    load_vec = CORNER_VEC0;
    if (state_q == ST_SAMPLE) begin
      if (nxt_from_lfsr) begin
        load_vec = vec_from_lfsr(lfsr_stepped);
      end else begin
        load_vec = corner_vec(nxt_idx[1:0]);
      end
    end
  end

  // FSM next-state, operand loading, capture and result bookkeeping.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cin_d     = cin_q;
    cap_d     = cap_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffi_d     = ffi_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          idx_d     = 8'd0;
          err_d     = 8'd0;
          ffi_d     = 8'd0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          lfsr_load = 1'b1;
          op_a_d    = load_vec.a;
          op_b_d    = load_vec.b;
          cin_d     = load_vec.cin;
        end
      end

      ST_DRIVE: begin
        // Adder has had a full period since the operands changed.
        cap_d   = {dut_cout, dut_sum};
        state_d = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = sat_inc8(err_q);
          if (err_q == 8'd0) begin
            ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 8'd0) && !mismatch;
        end else begin
          state_d   = ST_DRIVE;
          idx_d     = nxt_idx;
          lfsr_step = nxt_from_lfsr;
          op_a_d    = load_vec.a;
          op_b_d    = load_vec.b;
          cin_d     = load_vec.cin;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs clear immediately on reset; nothing survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cin_q   <= 1'b0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      ffi_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cin_q   <= cin_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign cin            = cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule
